wt_dcache_rd_arb: RTL and testbench



---
 rtl/wt_cache_pkg.sv | 16 +
 rtl/wt_dcache_rd_arb_chk.sv | 25 ++
 rtl/wt_dcache_rr_pick.sv | 35 +++
 rtl/wt_dcache_rd_arb.sv | 138 +++++++++++++
 tb/tb_wt_dcache_rd_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wt_cache_pkg.sv
// Shared dcache geometry and read-arbiter types.
package wt_cache_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH         = 20;
  localparam int unsigned DCACHE_CL_IDX_WIDTH      = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH      = 4;
  localparam int unsigned DCACHE_RD_ARB_MAX_STARVE = 255;

  typedef logic [7:0] rd_arb_cnt_t;

  // Saturating increment used by the starvation counter.
  function automatic rd_arb_cnt_t rd_arb_sat_inc(input rd_arb_cnt_t val, input rd_arb_cnt_t lim);
    return (val < lim) ? (val + 8'd1) : val;
  endfunction

endpackage

// File: rtl/wt_dcache_rd_arb_chk.sv
// Protocol checker for the dcache read arbiter request interface.
module wt_dcache_rd_arb_chk import wt_cache_pkg::*; #(
  parameter int unsigned NumPorts = 3
) (
  input logic                                               clk_i,
  input logic                                               rst_ni,
  input logic [NumPorts-1:0]                                rd_req_i,
  input logic [NumPorts-1:0]                                rd_ack_o,
  input logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]          rd_tag_i,
  input logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]       rd_idx_i,
  input logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]       rd_off_i,
  input logic                                               mem_req_o
);

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rd_req_i[i] && !rd_ack_o[i] |=> rd_req_i[i]);
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rd_req_i[i] && !rd_ack_o[i] |=> $stable(rd_tag_i[i]) && $stable(rd_idx_i[i]) && $stable(rd_off_i[i]));
  end

  a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rd_ack_o) && (mem_req_o == (|rd_ack_o)));

endmodule

// File: rtl/wt_dcache_rr_pick.sv
// Combinational masked round-robin picker: first requester at or after ptr_i, wrapping.
module wt_dcache_rr_pick #(
  parameter int unsigned NumPorts = 3,
  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                vld_o
);

  logic [NumPorts-1:0] masked_s;
  logic [NumPorts-1:0] sel_s;
  logic                found_s;

  // Prefer requesters at/after the pointer; fall back to the unmasked vector to wrap.
  always_comb begin
    masked_s = '0;
    gnt_o    = '0;
    idx_o    = '0;
    found_s  = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      masked_s[i] = req_i[i] && (i >= 32'(ptr_i));
    end
    sel_s = (|masked_s) ? masked_s : req_i;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      gnt_o[i] = sel_s[i] & ~found_s;
      found_s  = found_s | sel_s[i];
      idx_o    = idx_o | (gnt_o[i] ? IdxW'(i) : '0);
    end
    vld_o = |req_i;
  end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Dcache read-port arbiter with priority classes, shared round-robin and starvation promotion.
// Optional performance outputs are enabled with WT_DCACHE_RD_ARB_PERF_EN.
module wt_dcache_rd_arb import wt_cache_pkg::*; #(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned StarveLimit = 16,
  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NumPorts-1:0]                          rd_req_i,
  input  logic [NumPorts-1:0]                          rd_prio_i,
  input  logic [NumPorts-1:0]                          rd_tag_only_i,
  input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]    rd_tag_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0] rd_idx_i,
  input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0] rd_off_i,
  input  logic                                         wr_cl_vld_i,
  output logic [NumPorts-1:0]                          rd_ack_o,
  output logic                                         mem_req_o,
  output logic                                         mem_tag_only_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                  mem_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]               mem_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]               mem_off_o,
  output logic                                         rsp_vld_o,
  output logic [IdxW-1:0]                              rsp_port_o,
  output logic                                         rsp_tag_only_o,
  output logic                                         starve_o
`ifdef WT_DCACHE_RD_ARB_PERF_EN
  ,
  output logic                                         perf_conflict_o,
  output logic [31:0]                                  perf_starve_cnt_o
`endif
);

  localparam rd_arb_cnt_t Limit = (StarveLimit > DCACHE_RD_ARB_MAX_STARVE) ?
                                  rd_arb_cnt_t'(DCACHE_RD_ARB_MAX_STARVE) : rd_arb_cnt_t'(StarveLimit);

  logic [NumPorts-1:0] hi_req_s, lo_req_s, hi_gnt_s, lo_gnt_s, gnt_s;
  logic [IdxW-1:0]     hi_idx_s, lo_idx_s, win_idx_s, next_rr_s, rr_r;
  logic                hi_vld_s, lo_vld_s, use_lo_s, gnt_vld_s, arb_en_s, lo_won_s;
  rd_arb_cnt_t         cnt_r, cnt_d_s;
  logic                rsp_vld_r, rsp_tag_only_r;
  logic [IdxW-1:0]     rsp_port_r;

  assign hi_req_s = rd_req_i & rd_prio_i;
  assign lo_req_s = rd_req_i & ~rd_prio_i;

  wt_dcache_rr_pick #(.NumPorts(NumPorts)) i_pick_hi (
    .req_i (hi_req_s),
    .ptr_i (rr_r),
    .gnt_o (hi_gnt_s),
    .idx_o (hi_idx_s),
    .vld_o (hi_vld_s)
  );

  wt_dcache_rr_pick #(.NumPorts(NumPorts)) i_pick_lo (
    .req_i (lo_req_s),
    .ptr_i (rr_r),
    .gnt_o (lo_gnt_s),
    .idx_o (lo_idx_s),
    .vld_o (lo_vld_s)
  );

  assign starve_o = (cnt_r == Limit);

  // Class selection, grant gating, winner field mux and next counter/pointer values.
  always_comb begin
    arb_en_s  = rst_ni & ~wr_cl_vld_i;
    use_lo_s  = starve_o ? lo_vld_s : ~hi_vld_s;
    gnt_s     = arb_en_s ? (use_lo_s ? lo_gnt_s : hi_gnt_s) : '0;
    win_idx_s = use_lo_s ? lo_idx_s : hi_idx_s;
    gnt_vld_s = |gnt_s;
    next_rr_s = (32'(win_idx_s) == NumPorts - 1) ? '0 : (win_idx_s + IdxW'(1));
    lo_won_s  = |(gnt_s & ~rd_prio_i);
    cnt_d_s   = (!lo_vld_s || lo_won_s) ? 8'd0 : rd_arb_sat_inc(cnt_r, Limit);
    if (gnt_vld_s) begin
      mem_tag_only_o = rd_tag_only_i[win_idx_s];
      mem_tag_o      = rd_tag_i[win_idx_s];
      mem_idx_o      = rd_idx_i[win_idx_s];
      mem_off_o      = rd_off_i[win_idx_s];
    end else begin
      mem_tag_only_o = 1'b0;
      mem_tag_o      = '0;
      mem_idx_o      = '0;
      mem_off_o      = '0;
    end
  end

  assign rd_ack_o  = gnt_s;
  assign mem_req_o = gnt_vld_s;

  // Round-robin pointer, starvation counter and one-cycle response pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r           <= '0;
      cnt_r          <= 8'd0;
      rsp_vld_r      <= 1'b0;
      rsp_port_r     <= '0;
      rsp_tag_only_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_d_s;
      rsp_vld_r <= gnt_vld_s;
      if (gnt_vld_s) begin
        rr_r           <= next_rr_s;
        rsp_port_r     <= win_idx_s;
        rsp_tag_only_r <= rd_tag_only_i[win_idx_s];
      end
    end
  end

  assign rsp_vld_o      = rsp_vld_r;
  assign rsp_port_o     = rsp_port_r;
  assign rsp_tag_only_o = rsp_tag_only_r;

`ifdef WT_DCACHE_RD_ARB_PERF_EN
  logic        starve_prev_r;
  logic [31:0] perf_starve_cnt_r;

  // Two or more pending requests, or a refill blocking any pending request.
  assign perf_conflict_o = ((rd_req_i & (rd_req_i - NumPorts'(1))) != '0) ||
                           (wr_cl_vld_i && (|rd_req_i));

  // Count rising edges of the promotion flag (wraps naturally).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_prev_r     <= 1'b0;
      perf_starve_cnt_r <= 32'd0;
    end else begin
      starve_prev_r <= starve_o;
      if (starve_o && !starve_prev_r) begin
        perf_starve_cnt_r <= perf_starve_cnt_r + 32'd1;
      end
    end
  end

  assign perf_starve_cnt_o = perf_starve_cnt_r;
`endif

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Scoreboard bench for wt_dcache_rd_arb: reference arbitration model plus response monitor.
module tb_wt_dcache_rd_arb;
  import wt_cache_pkg::*;

  localparam int NP = 3;
  localparam int SL = 4;

  typedef struct {
    int port;
    bit tag_only;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NP-1:0] rd_req_i = '0, rd_prio_i = '0, rd_tag_only_i = '0;
  logic [NP-1:0][DCACHE_TAG_WIDTH-1:0]    rd_tag_i = '0;
  logic [NP-1:0][DCACHE_CL_IDX_WIDTH-1:0] rd_idx_i = '0;
  logic [NP-1:0][DCACHE_OFFSET_WIDTH-1:0] rd_off_i = '0;
  logic wr_cl_vld_i = 1'b0;
  logic [NP-1:0] rd_ack_o;
  logic mem_req_o, mem_tag_only_o, rsp_vld_o, rsp_tag_only_o, starve_o;
  logic [DCACHE_TAG_WIDTH-1:0]    mem_tag_o;
  logic [DCACHE_CL_IDX_WIDTH-1:0] mem_idx_o;
  logic [DCACHE_OFFSET_WIDTH-1:0] mem_off_o;
  logic [1:0] rsp_port_o;

  int n_chk = 0;
  int n_fail = 0;
  int m_rr = 0;
  int m_cnt = 0;
  exp_t q[$];

  always #5 clk_i = ~clk_i;

  wt_dcache_rd_arb #(.NumPorts(NP), .StarveLimit(SL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rd_req_i(rd_req_i), .rd_prio_i(rd_prio_i),
    .rd_tag_only_i(rd_tag_only_i), .rd_tag_i(rd_tag_i), .rd_idx_i(rd_idx_i), .rd_off_i(rd_off_i),
    .wr_cl_vld_i(wr_cl_vld_i), .rd_ack_o(rd_ack_o), .mem_req_o(mem_req_o),
    .mem_tag_only_o(mem_tag_only_o), .mem_tag_o(mem_tag_o), .mem_idx_o(mem_idx_o),
    .mem_off_o(mem_off_o), .rsp_vld_o(rsp_vld_o), .rsp_port_o(rsp_port_o),
    .rsp_tag_only_o(rsp_tag_only_o), .starve_o(starve_o)
  );

  wt_dcache_rd_arb_chk #(.NumPorts(NP)) chk (
    .clk_i(clk_i), .rst_ni(rst_ni), .rd_req_i(rd_req_i), .rd_ack_o(rd_ack_o),
    .rd_tag_i(rd_tag_i), .rd_idx_i(rd_idx_i), .rd_off_i(rd_off_i), .mem_req_o(mem_req_o)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference: pick the active class, then the first requester from the pointer onward.
  function automatic int model_pick(input logic [NP-1:0] req, input logic [NP-1:0] prio,
                                    input bit starve, input int rr);
    logic [NP-1:0] hi, lo, c;
    hi = req & prio;
    lo = req & ~prio;
    if (starve) c = (lo != 0) ? lo : hi;
    else        c = (hi != 0) ? hi : lo;
    for (int k = 0; k < NP; k++) begin
      if (c[(rr + k) % NP]) return (rr + k) % NP;
    end
    return -1;
  endfunction

  // One arbitration cycle: inputs are already applied just after a rising edge.
  task automatic step(input bit wr, output int w);
    bit starve, lo_pend;
    logic [NP-1:0] eack;
    logic [DCACHE_TAG_WIDTH-1:0] etag;
    logic [DCACHE_CL_IDX_WIDTH-1:0] eidx;
    logic [DCACHE_OFFSET_WIDTH-1:0] eoff;
    logic eto;
    wr_cl_vld_i = wr;
    starve = (m_cnt == SL);
    w = wr ? -1 : model_pick(rd_req_i, rd_prio_i, starve, m_rr);
    eack = '0; etag = '0; eidx = '0; eoff = '0; eto = 1'b0;
    if (w >= 0) begin
      eack[w] = 1'b1;
      etag = rd_tag_i[w];
      eidx = rd_idx_i[w];
      eoff = rd_off_i[w];
      eto  = rd_tag_only_i[w];
    end
    @(negedge clk_i);
    check("rd_ack", 64'(rd_ack_o), 64'(eack));
    check("mem_req", 64'(mem_req_o), 64'(w >= 0));
    check("starve", 64'(starve_o), 64'(starve));
    check("mem_tag", 64'(mem_tag_o), 64'(etag));
    check("mem_idx", 64'(mem_idx_o), 64'(eidx));
    check("mem_off", 64'(mem_off_o), 64'(eoff));
    check("mem_tag_only", 64'(mem_tag_only_o), 64'(eto));
    @(posedge clk_i);
    lo_pend = |(rd_req_i & ~rd_prio_i);
    if (w >= 0) begin
      q.push_back('{w, eto});
      m_rr = (w + 1) % NP;
    end
    if (!lo_pend || (w >= 0 && !rd_prio_i[w])) m_cnt = 0;
    else if (m_cnt < SL) m_cnt++;
    #1;
  endtask

  task automatic drain();
    int w;
    for (int k = 0; k < 12 && rd_req_i != '0; k++) begin
      step(1'b0, w);
      if (w >= 0) rd_req_i[w] = 1'b0;
    end
    if (rd_req_i != '0) fail("drain_timeout");
    rd_req_i = '0;
    step(1'b0, w);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ack"}, 64'(rd_ack_o), 64'd0);
    check({nm, "_mem_req"}, 64'(mem_req_o), 64'd0);
    check({nm, "_rsp_vld"}, 64'(rsp_vld_o), 64'd0);
    check({nm, "_rsp_port"}, 64'(rsp_port_o), 64'd0);
    check({nm, "_rsp_tag_only"}, 64'(rsp_tag_only_o), 64'd0);
    check({nm, "_starve"}, 64'(starve_o), 64'd0);
    check({nm, "_mem_fields"}, 64'({mem_tag_o, mem_idx_o, mem_off_o, mem_tag_only_o}), 64'd0);
  endtask

  // Response monitor: every registered response must match the oldest outstanding grant.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (rsp_vld_o) begin
        if (q.size() == 0) fail("rsp_unexpected");
        else begin
          e = q.pop_front();
          check("rsp_port", 64'(rsp_port_o), 64'(e.port));
          check("rsp_tag_only", 64'(rsp_tag_only_o), 64'(e.tag_only));
        end
      end else if (q.size() != 0) begin
        fail("rsp_missing");
        q.delete();
      end
    end
  end

  initial begin
    int w;
    int k;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Two high-priority ports alternate from pointer 0.
    rd_prio_i = 3'b011;
    rd_req_i  = 3'b011;
    for (int i = 0; i < NP; i++) begin
      rd_tag_i[i] = DCACHE_TAG_WIDTH'(32'h100 + i);
      rd_idx_i[i] = DCACHE_CL_IDX_WIDTH'(i + 1);
      rd_off_i[i] = DCACHE_OFFSET_WIDTH'(i + 2);
    end
    repeat (3) step(1'b0, w);
    drain();

    // Low-priority port 2 starves for SL cycles, then gets promoted.
    rd_req_i = 3'b111;
    repeat (7) step(1'b0, w);
    drain();

    // Refill stall blocks a pending request for three cycles.
    rd_prio_i = 3'b001;
    rd_req_i  = 3'b001;
    repeat (3) step(1'b1, w);
    step(1'b0, w);
    rd_req_i = '0;
    step(1'b0, w);

    // Promotion held across a refill stall reaching the limit.
    rd_prio_i = 3'b011;
    rd_req_i  = 3'b111;
    for (k = 0; k < 20 && m_cnt != SL; k++) step(1'b0, w);
    if (m_cnt != SL) fail("starve_not_reached");
    step(1'b1, w);
    step(1'b1, w);
    step(1'b0, w);
    drain();

    // Field mux and registered tag_only.
    rd_tag_only_i = 3'b010;
    rd_idx_i[1] = DCACHE_CL_IDX_WIDTH'(8'h2A);
    rd_off_i[1] = DCACHE_OFFSET_WIDTH'(4'h8);
    rd_tag_i[1] = DCACHE_TAG_WIDTH'(20'hABCDE);
    rd_req_i = 3'b010;
    step(1'b0, w);
    rd_req_i = '0;
    step(1'b0, w);

    // Reset asserted while a response would rise.
    rd_prio_i = 3'b111;
    rd_req_i  = 3'b010;
    @(negedge clk_i);
    check("pre_reset_ack", 64'(rd_ack_o), 64'(3'b010));
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    q.delete();
    check_all_zero("mid_reset");
    rd_req_i = '0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    m_rr = 0;
    m_cnt = 0;
    rd_prio_i = 3'b110;
    rd_req_i  = 3'b110;
    step(1'b0, w);
    drain();

    // Randomized traffic; requests hold stable until acked.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!rd_req_i[i] && $urandom_range(0, 99) < 55) begin
          rd_req_i[i]      = 1'b1;
          rd_prio_i[i]     = (i == NP - 1) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
          rd_tag_only_i[i] = 1'($urandom_range(0, 1));
          rd_tag_i[i]      = DCACHE_TAG_WIDTH'($urandom);
          rd_idx_i[i]      = DCACHE_CL_IDX_WIDTH'($urandom);
          rd_off_i[i]      = DCACHE_OFFSET_WIDTH'($urandom);
        end
      end
      step($urandom_range(0, 99) < 15, w);
      if (w >= 0) rd_req_i[w] = 1'b0;
    end
    drain();
    @(negedge clk_i);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
